// File: rtl/sec32_corrector.sv
// Registered 32-bit single-error-correcting decoder (c1355 function class).
// Syndrome over an 8-bit H-matrix; the matching data bit is flipped when enabled.
module sec32_corrector (
  input  logic clock,
  input  logic reset,
  input  logic input_0,  input_1,  input_2,  input_3,  input_4,  input_5,  input_6,  input_7,
  input  logic input_8,  input_9,  input_10, input_11, input_12, input_13, input_14, input_15,
  input  logic input_16, input_17, input_18, input_19, input_20, input_21, input_22, input_23,
  input  logic input_24, input_25, input_26, input_27, input_28, input_29, input_30, input_31,
  input  logic input_32, input_33, input_34, input_35, input_36, input_37, input_38, input_39,
  input  logic input_40,
  output logic po0,  po1,  po2,  po3,  po4,  po5,  po6,  po7,
  output logic po8,  po9,  po10, po11, po12, po13, po14, po15,
  output logic po16, po17, po18, po19, po20, po21, po22, po23,
  output logic po24, po25, po26, po27, po28, po29, po30, po31
);

  logic [31:0] id;
  logic [7:0]  ic;
  logic        r;
  logic [7:0]  s;
  logic [31:0] c;
  logic [31:0] od;
  logic [31:0] po_q;

  assign id = {input_31, input_30, input_29, input_28, input_27, input_26, input_25, input_24,
               input_23, input_22, input_21, input_20, input_19, input_18, input_17, input_16,
               input_15, input_14, input_13, input_12, input_11, input_10, input_9,  input_8,
               input_7,  input_6,  input_5,  input_4,  input_3,  input_2,  input_1,  input_0};
  assign ic = {input_39, input_38, input_37, input_36, input_35, input_34, input_33, input_32};
  assign r  = input_40;

  // Column i: low nibble one-hot on i%4, high nibble is group number i/4 plus one.
  function automatic logic [7:0] col(input int unsigned i);
    logic [3:0] hi;
    logic [3:0] lo;
    hi  = 4'(i / 4 + 1);
    lo  = 4'(1 << (i % 4));
    col = {hi, lo};
  endfunction

  always_comb begin
    s = ic;
    for (int unsigned i = 0; i < 32; i++) begin
      if (id[i]) s = s ^ col(i);
    end
  end

  // Columns are distinct, so at most one c bit can match.
  always_comb begin
    c = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      c[i] = r && (s == col(i));
    end
  end

  assign od = id ^ c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) po_q <= '0;
    else       po_q <= od;
  end

  assign {po31, po30, po29, po28, po27, po26, po25, po24,
          po23, po22, po21, po20, po19, po18, po17, po16,
          po15, po14, po13, po12, po11, po10, po9,  po8,
          po7,  po6,  po5,  po4,  po3,  po2,  po1,  po0} = po_q;

endmodule

// File: tb/tb_sec32_corrector.sv
// Self-checking bench for sec32_corrector: directed cases plus randomized
// stimulus against a syndrome-decoding reference model.
module tb_sec32_corrector;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] id    = '0;
  logic [7:0]  ic    = '0;
  logic        r     = 1'b0;
  wire  [31:0] po;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sec32_corrector dut (
    .clock(clock), .reset(reset),
    .input_0(id[0]),   .input_1(id[1]),   .input_2(id[2]),   .input_3(id[3]),
    .input_4(id[4]),   .input_5(id[5]),   .input_6(id[6]),   .input_7(id[7]),
    .input_8(id[8]),   .input_9(id[9]),   .input_10(id[10]), .input_11(id[11]),
    .input_12(id[12]), .input_13(id[13]), .input_14(id[14]), .input_15(id[15]),
    .input_16(id[16]), .input_17(id[17]), .input_18(id[18]), .input_19(id[19]),
    .input_20(id[20]), .input_21(id[21]), .input_22(id[22]), .input_23(id[23]),
    .input_24(id[24]), .input_25(id[25]), .input_26(id[26]), .input_27(id[27]),
    .input_28(id[28]), .input_29(id[29]), .input_30(id[30]), .input_31(id[31]),
    .input_32(ic[0]),  .input_33(ic[1]),  .input_34(ic[2]),  .input_35(ic[3]),
    .input_36(ic[4]),  .input_37(ic[5]),  .input_38(ic[6]),  .input_39(ic[7]),
    .input_40(r),
    .po0(po[0]),   .po1(po[1]),   .po2(po[2]),   .po3(po[3]),
    .po4(po[4]),   .po5(po[5]),   .po6(po[6]),   .po7(po[7]),
    .po8(po[8]),   .po9(po[9]),   .po10(po[10]), .po11(po[11]),
    .po12(po[12]), .po13(po[13]), .po14(po[14]), .po15(po[15]),
    .po16(po[16]), .po17(po[17]), .po18(po[18]), .po19(po[19]),
    .po20(po[20]), .po21(po[21]), .po22(po[22]), .po23(po[23]),
    .po24(po[24]), .po25(po[25]), .po26(po[26]), .po27(po[27]),
    .po28(po[28]), .po29(po[29]), .po30(po[30]), .po31(po[31])
  );

  // Parity-count syndrome: bit j<4 covers data bits with i%4==j,
  // bit j>=4 covers data bits whose group number (i/4+1) has bit j-4 set.
  function automatic logic [7:0] syndrome(input logic [31:0] d, input logic [7:0] c);
    logic [7:0] s;
    for (int j = 0; j < 8; j++) begin
      int cnt;
      cnt = 0;
      for (int i = 0; i < 32; i++) begin
        if (d[i]) begin
          if (j < 4) cnt += (i % 4 == j) ? 1 : 0;
          else       cnt += ((i / 4 + 1) >> (j - 4)) & 1;
        end
      end
      s[j] = c[j] ^ cnt[0];
    end
    return s;
  endfunction

  // Decode the syndrome into a bit position, then flip it if enabled.
  function automatic logic [31:0] model(input logic [31:0] d, input logic [7:0] c, input logic en);
    logic [7:0]  s;
    logic [31:0] out;
    int k;
    int h;
    s   = syndrome(d, c);
    out = d;
    h   = int'(s[7:4]);
    case (s[3:0])
      4'h1: k = 0;
      4'h2: k = 1;
      4'h4: k = 2;
      4'h8: k = 3;
      default: k = -1;
    endcase
    if (en && k >= 0 && h >= 1 && h <= 8) out[(h - 1) * 4 + k] = ~out[(h - 1) * 4 + k];
    return out;
  endfunction

  task automatic drive(input logic [31:0] d, input logic [7:0] c, input logic en);
    @(negedge clock);
    id = d; ic = c; r = en;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (po !== 32'h0) begin errors++; $display("FAIL reset_async po=%h exp=%h", po, 32'h0); end
    drive(32'hFFFF_FFFF, 8'h00, 1'b0);
    checks++;
    if (po !== 32'h0) begin errors++; $display("FAIL reset_hold_edge po=%h exp=%h", po, 32'h0); end
    @(negedge clock);
    id = '0; ic = '0; r = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (po !== 32'h0) begin errors++; $display("FAIL reset_first_edge po=%h exp=%h", po, 32'h0); end
  endtask

  task automatic test_directed;
    logic [31:0] d_tab [6] = '{32'hFFFF_FFFF, 32'h0000_0020, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0000};
    logic [7:0]  c_tab [6] = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h22};
    logic        e_tab [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] x_tab [6] = '{32'hFFFF_FFFF, 32'h0, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0020};
    for (int n = 0; n < 6; n++) begin
      drive(d_tab[n], c_tab[n], e_tab[n]);
      checks++;
      if (po !== x_tab[n]) begin
        errors++; $display("FAIL directed_%0d po=%h exp=%h", n, po, x_tab[n]);
      end
    end
  endtask

  task automatic test_walk;
    for (int i = 0; i < 32; i++) begin
      drive(32'h1 << i, 8'h00, 1'b1);
      checks++;
      if (po !== 32'h0) begin errors++; $display("FAIL walk_%0d po=%h exp=%h", i, po, 32'h0); end
    end
  endtask

  task automatic test_codeword_correct;
    for (int n = 0; n < 64; n++) begin
      logic [31:0] d;
      logic [7:0]  c;
      int unsigned b;
      d = $urandom;
      c = syndrome(d, 8'h00);
      b = $urandom_range(31, 0);
      drive(d ^ (32'h1 << b), c, 1'b1);
      checks++;
      if (po !== d) begin errors++; $display("FAIL correct_bit%0d po=%h exp=%h", b, po, d); end
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 200; n++) begin
      logic [31:0] d;
      logic [7:0]  c;
      logic        e;
      logic [31:0] x;
      d = $urandom;
      c = 8'($urandom);
      e = 1'($urandom);
      if (n % 4 == 0) c = syndrome(d ^ (32'h1 << $urandom_range(31, 0)), 8'h00);
      x = model(d, c, e);
      drive(d, c, e);
      checks++;
      if (po !== x) begin errors++; $display("FAIL random_%0d po=%h exp=%h", n, po, x); end
    end
  endtask

  task automatic test_latency;
    drive(32'h1234_5678, 8'h00, 1'b0);
    @(negedge clock);
    id = 32'hCAFE_0001; ic = 8'h00; r = 1'b0;
    #1;
    checks++;
    if (po !== 32'h1234_5678) begin errors++; $display("FAIL latency_hold po=%h exp=%h", po, 32'h1234_5678); end
    @(posedge clock); #1;
    checks++;
    if (po !== 32'hCAFE_0001) begin errors++; $display("FAIL latency_update po=%h exp=%h", po, 32'hCAFE_0001); end
  endtask

  task automatic test_reset_mid;
    drive(32'h0000_0020, 8'h00, 1'b0);
    checks++;
    if (po !== 32'h0000_0020) begin errors++; $display("FAIL mid_setup po=%h exp=%h", po, 32'h20); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (po !== 32'h0) begin errors++; $display("FAIL mid_async_clear po=%h exp=%h", po, 32'h0); end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (po !== 32'h0) begin errors++; $display("FAIL mid_hold_after_release po=%h exp=%h", po, 32'h0); end
    @(posedge clock); #1;
    checks++;
    if (po !== 32'h0000_0020) begin errors++; $display("FAIL mid_first_edge po=%h exp=%h", po, 32'h20); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_walk;
    test_codeword_correct;
    test_random;
    test_latency;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
